// File: rtl/forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Shadow-tracks the EX, MEM and WB stages of a 5-stage in-order pipeline and
// produces:
//   * EX operand forwarding selects (00 = register file, 10 = EX/MEM result,
//     11 = MEM/WB result; 01 is never produced),
//   * a one-cycle load-use stall,
//   * a flush on a taken branch/jump (a flush always overrides a stall).
//
// Optional build feature: define HAZARD_PERF_EN to add the 32-bit
// stall_cycles / flush_cycles performance counters and their output ports.
// Without the macro the ports and counters do not exist and the behaviour is
// otherwise identical.
//
// The register file is write-first, so a WB write that lands in the same
// cycle as the ID read needs no help from this block.
// -----------------------------------------------------------------------------
module forwarding_hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        branch_taken,
    output logic [1:0]  op1_fwd_src,
    output logic [1:0]  op2_fwd_src,
    output logic        stall,
    output logic        flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    // Operand select encodings
    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b11;
    localparam logic [4:0] REG_X0    = 5'd0;

    // -------------------------------------------------------------------------
    // Shadow slot state
    // -------------------------------------------------------------------------
    logic       ex_valid_r;
    logic [4:0] ex_rs1_r;
    logic [4:0] ex_rs2_r;
    logic [4:0] ex_rd_r;
    logic       ex_regwrite_r;
    logic       ex_memread_r;

    logic       mem_valid_r;
    logic [4:0] mem_rd_r;
    logic       mem_regwrite_r;
    logic       mem_memread_r;

    logic       wb_valid_r;
    logic [4:0] wb_rd_r;
    logic       wb_regwrite_r;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic op1_mem_hit_s;
    logic op1_wb_hit_s;
    logic op2_mem_hit_s;
    logic op2_wb_hit_s;
    logic load_use_s;
    logic bubble_s;
    logic unused_s;

    // True when a slot holds a live write to a non-x0 register equal to src.
    function automatic logic slot_writes(
        input logic       valid,
        input logic       regwrite,
        input logic [4:0] rd,
        input logic [4:0] src
    );
        return valid & regwrite & (rd != REG_X0) & (rd == src);
    endfunction

    // The younger producer (MEM slot) wins over the older one (WB slot).
    function automatic logic [1:0] fwd_select(
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        if (mem_hit) begin
            sel = SEL_EXMEM;
        end else if (wb_hit) begin
            sel = SEL_MEMWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Match the EX operands against the MEM and WB producers.
    always_comb begin
        op1_mem_hit_s = slot_writes(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rs1_r);
        op1_wb_hit_s  = slot_writes(wb_valid_r,  wb_regwrite_r,  wb_rd_r,  ex_rs1_r);
        op2_mem_hit_s = slot_writes(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rs2_r);
        op2_wb_hit_s  = slot_writes(wb_valid_r,  wb_regwrite_r,  wb_rd_r,  ex_rs2_r);
    end

    // Detect an ID instruction reading the destination of a load sitting in EX.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_valid_r && ex_memread_r && (ex_rd_r != REG_X0) && id_valid) begin
            load_use_s = (id_uses_rs1 && (id_rs1 == ex_rd_r)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd_r));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Drive the hazard outputs; reset forces everything quiet, flush beats stall.
    always_comb begin
        op1_fwd_src = SEL_RF;
        op2_fwd_src = SEL_RF;
        stall       = 1'b0;
        flush       = 1'b0;
        if (rst) begin
            op1_fwd_src = SEL_RF;
            op2_fwd_src = SEL_RF;
            stall       = 1'b0;
            flush       = 1'b0;
        end else begin
            op1_fwd_src = fwd_select(op1_mem_hit_s, op1_wb_hit_s);
            op2_fwd_src = fwd_select(op2_mem_hit_s, op2_wb_hit_s);
            flush       = branch_taken;
            if (branch_taken) begin
                stall = 1'b0;
            end else begin
                stall = load_use_s;
            end
        end
    end

    assign bubble_s = stall | flush;

    // The MEM load flag is kept for completeness of the MEM shadow slot; no
    // output depends on it because the stall keeps dependents out of EX.
    assign unused_s = mem_memread_r;

    // Advance the shadow pipeline: WB <- MEM, MEM <- EX, EX <- ID or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r     <= 1'b0;
            ex_rs1_r       <= 5'd0;
            ex_rs2_r       <= 5'd0;
            ex_rd_r        <= 5'd0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            mem_valid_r    <= 1'b0;
            mem_rd_r       <= 5'd0;
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= 5'd0;
            wb_regwrite_r  <= 1'b0;
        end else begin
            wb_valid_r     <= mem_valid_r;
            wb_rd_r        <= mem_rd_r;
            wb_regwrite_r  <= mem_regwrite_r;

            mem_valid_r    <= ex_valid_r;
            mem_rd_r       <= ex_rd_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memread_r  <= ex_memread_r;

            if (bubble_s) begin
                // A bubble is a fully zeroed slot so it can never match x0+
                ex_valid_r    <= 1'b0;
                ex_rs1_r      <= 5'd0;
                ex_rs2_r      <= 5'd0;
                ex_rd_r       <= 5'd0;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
            end else begin
                ex_valid_r    <= id_valid;
                ex_rs1_r      <= id_rs1;
                ex_rs2_r      <= id_rs2;
                ex_rd_r       <= id_rd;
                ex_regwrite_r <= id_regwrite;
                ex_memread_r  <= id_memread;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_cycles_r;

    // Count stall cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (stall) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    // Count flush cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cycles_r <= 32'd0;
        end else if (flush) begin
            flush_cycles_r <= flush_cycles_r + 32'd1;
        end else begin
            flush_cycles_r <= flush_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_cycles = flush_cycles_r;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for forwarding_hazard_unit.
// A small instruction-level model (array of in-flight instructions) predicts
// the outputs every cycle; directed sequences add literal expectations.
// Define HAZARD_PERF_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        branch_taken;
    logic [1:0]  op1_fwd_src;
    logic [1:0]  op2_fwd_src;
    logic        stall;
    logic        flush;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .branch_taken (branch_taken),
        .op1_fwd_src  (op1_fwd_src),
        .op2_fwd_src  (op2_fwd_src),
        .stall        (stall),
        .flush        (flush)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    instr_t      pipe [3];
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;
    logic        last_stall;

    // Sampled DUT outputs of the most recent step
    logic [1:0]  s_op1;
    logic [1:0]  s_op2;
    logic        s_stall;
    logic        s_flush;
    logic [31:0] s_scnt;
    logic [31:0] s_fcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic [4:0] rd,
                                  input logic rw, input logic mr);
        instr_t t;
        t.valid = 1'b1; t.rs1 = rs1; t.rs2 = rs2; t.use1 = u1; t.use2 = u2;
        t.rd = rd; t.regwrite = rw; t.memread = mr;
        return t;
    endfunction

    // Youngest live producer of src among MEM (->10) and WB (->11), x0 excluded
    function automatic logic [1:0] model_sel(input logic [4:0] src);
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].valid && pipe[k].regwrite && pipe[k].rd != 5'd0 && pipe[k].rd == src)
                return (k == 1) ? 2'b10 : 2'b11;
        end
        return 2'b00;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.valid    = ($urandom_range(0, 7) != 0);
        t.rs1      = 5'($urandom_range(0, 3));
        t.rs2      = 5'($urandom_range(0, 3));
        t.use1     = 1'($urandom_range(0, 1));
        t.use2     = 1'($urandom_range(0, 1));
        t.rd       = 5'($urandom_range(0, 3));
        t.memread  = ($urandom_range(0, 2) == 0);
        t.regwrite = t.memread | 1'($urandom_range(0, 1));
        return t;
    endfunction

    // One clock: drive ID, check all outputs against the model, advance model.
    task automatic step(input instr_t ins, input logic r, input logic b);
        logic [1:0] e_op1, e_op2;
        logic       e_stall, e_flush, hazard;
        id_valid = ins.valid; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
        id_uses_rs1 = ins.use1; id_uses_rs2 = ins.use2; id_rd = ins.rd;
        id_regwrite = ins.regwrite; id_memread = ins.memread;
        rst = r; branch_taken = b;
        @(negedge clk);
        hazard = pipe[0].valid && pipe[0].memread && pipe[0].rd != 5'd0 && ins.valid &&
                 ((ins.use1 && ins.rs1 == pipe[0].rd) || (ins.use2 && ins.rs2 == pipe[0].rd));
        e_op1   = r ? 2'b00 : model_sel(pipe[0].rs1);
        e_op2   = r ? 2'b00 : model_sel(pipe[0].rs2);
        e_flush = !r && b;
        e_stall = !r && !b && hazard;
        s_op1 = op1_fwd_src; s_op2 = op2_fwd_src; s_stall = stall; s_flush = flush;
        chk("op1_fwd_src", 32'(s_op1), 32'(e_op1));
        chk("op2_fwd_src", 32'(s_op2), 32'(e_op2));
        chk("stall", 32'(s_stall), 32'(e_stall));
        chk("flush", 32'(s_flush), 32'(e_flush));
`ifdef HAZARD_PERF_EN
        s_scnt = stall_cycles; s_fcnt = flush_cycles;
        chk("stall_cycles", s_scnt, m_stall_cnt);
        chk("flush_cycles", s_fcnt, m_flush_cnt);
`else
        s_scnt = 32'd0; s_fcnt = 32'd0;
`endif
        last_stall = e_stall;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            m_stall_cnt = 32'd0;
            m_flush_cnt = 32'd0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e_stall || e_flush) ? instr_t'(0) : ins;
            m_stall_cnt = m_stall_cnt + (e_stall ? 32'd1 : 32'd0);
            m_flush_cnt = m_flush_cnt + (e_flush ? 32'd1 : 32'd0);
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(instr_t'(0), 1'b0, 1'b0);
    endtask

    initial begin
        instr_t cur;
        instr_t nop;
        nop = '0;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
        last_stall  = 1'b0;

        // Reset with busy inputs and a taken branch: outputs must stay quiet
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1), 1'b1, 1'b1);
        step(mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0), 1'b1, 1'b1);
        chk("reset_flush", 32'(s_flush), 32'd0);
        chk("reset_stall", 32'(s_stall), 32'd0);
        drain();

        // add x5 ; sub x6,x5,x7  -> op1 from EX/MEM
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0), 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0);
        chk("exmem_fwd_op1", 32'(s_op1), 32'd2);
        chk("exmem_fwd_op2", 32'(s_op2), 32'd0);
        drain();

        // add x5 ; nop ; or x8,x9,x5  -> op2 from MEM/WB
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0);
        step(mk(5'd9, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0), 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0);
        chk("memwb_fwd_op2", 32'(s_op2), 32'd3);
        chk("memwb_fwd_op1", 32'(s_op1), 32'd0);
        drain();

        // lw x5 ; add x6,x5,x5  -> one stall, bubble, then both 11
        step(mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b0);
        cur = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        step(cur, 1'b0, 1'b0);
        chk("load_use_stall", 32'(s_stall), 32'd1);
        step(cur, 1'b0, 1'b0);
        chk("load_use_stall_one_cycle", 32'(s_stall), 32'd0);
        chk("bubble_op1", 32'(s_op1), 32'd0);
        step(nop, 1'b0, 1'b0);
        chk("load_fwd_op1", 32'(s_op1), 32'd3);
        chk("load_fwd_op2", 32'(s_op2), 32'd3);
        drain();

        // add x5 ; add x5 ; sub x1,x5,x0  -> younger wins, x0 not forwarded
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd5, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0), 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0);
        chk("younger_wins_op1", 32'(s_op1), 32'd2);
        chk("x0_src_op2", 32'(s_op2), 32'd0);
        drain();

        // writes to x0 then use of x0 -> both 00
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0);
        step(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("x0_load_no_stall", 32'(s_stall), 32'd0);
        step(nop, 1'b0, 1'b0);
        chk("x0_op1", 32'(s_op1), 32'd0);
        chk("x0_op2", 32'(s_op2), 32'd0);
        drain();

        // lw x5 ; add x6,x5 with branch taken -> flush wins, EX bubble
        step(mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b0);
        step(mk(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0), 1'b0, 1'b1);
        chk("flush_wins_flush", 32'(s_flush), 32'd1);
        chk("flush_wins_stall", 32'(s_stall), 32'd0);
        step(nop, 1'b0, 1'b0);
        chk("flush_bubble_op1", 32'(s_op1), 32'd0);
        chk("flush_bubble_op2", 32'(s_op2), 32'd0);
        drain();

        // Mid-stream reset with pending dependencies: no stale forwarding
        step(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        step(mk(5'd6, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0), 1'b1, 1'b1);
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_flush", 32'(s_flush), 32'd0);
        step(nop, 1'b0, 1'b0);
        chk("post_rst_op1", 32'(s_op1), 32'd0);
        chk("post_rst_op2", 32'(s_op2), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("post_rst_stall_cycles", s_scnt, 32'd0);
        chk("post_rst_flush_cycles", s_fcnt, 32'd0);
`endif
        drain();

        // Randomized traffic; ID is held while a stall is reported
        cur = nop;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) cur = rand_instr();
            step(cur, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
